// File: rtl/rv32_pkg.sv
// Shared RV32 core types: register-file geometry and the writeback request payload.
package rv32_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_req_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback arbitration bus: ALU/LSU requests, register-file write port and decode busy lookup.
interface rf_wb_arbiter_if;
   import rv32_pkg::*;

   logic                  alu_valid;
   logic [REG_ADDR_W-1:0] alu_rd;
   logic [XLEN-1:0]       alu_data;
   logic                  alu_stall;
   logic                  lsu_valid;
   logic                  lsu_ready;
   logic [REG_ADDR_W-1:0] lsu_rd;
   logic [XLEN-1:0]       lsu_data;
   logic                  wen;
   logic [REG_ADDR_W-1:0] rd;
   logic [XLEN-1:0]       Rd_dat;
   logic [REG_ADDR_W-1:0] rs1;
   logic [REG_ADDR_W-1:0] rs2;
   logic                  rs1_busy;
   logic                  rs2_busy;

   modport master (
      output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, rs1, rs2,
      input  alu_stall, lsu_ready, wen, rd, Rd_dat, rs1_busy, rs2_busy
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, rs1, rs2,
      output alu_stall, lsu_ready, wen, rd, Rd_dat, rs1_busy, rs2_busy
   );

endinterface

// File: rtl/rf_wb_queue.sv
// Circular buffer of pending load writebacks with per-entry valid bits,
// squash-by-destination and a two-port busy lookup for decode.
module rf_wb_queue
   import rv32_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_push,
   input  logic [REG_ADDR_W-1:0] i_push_rd,
   input  logic [XLEN-1:0]       i_push_data,
   input  logic                  i_pop,
   input  logic                  i_squash,
   input  logic [REG_ADDR_W-1:0] i_squash_rd,
   input  logic [REG_ADDR_W-1:0] i_rs1,
   input  logic [REG_ADDR_W-1:0] i_rs2,
   output wb_req_t               o_head_c,
   output logic                  o_empty_c,
   output logic                  o_full_c,
   output logic                  o_rs1_busy_c,
   output logic                  o_rs2_busy_c
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   wb_req_t          r_ent [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign o_empty_c = (r_count == '0);
   assign o_full_c  = (r_count == CNT_W'(DEPTH));
   assign o_head_c  = o_empty_c ? '0 : r_ent[r_rptr];
   assign w_push    = i_push & ~o_full_c;
   assign w_pop     = i_pop & ~o_empty_c;

   // Squash first so a same-edge push to the squashed rd still lands valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_ent[PTR_W'(i)] <= '0;
         end
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (i_squash && (r_ent[PTR_W'(i)].rd == i_squash_rd)) begin
               r_ent[PTR_W'(i)].valid <= 1'b0;
            end
         end
         if (w_pop) begin
            r_ent[r_rptr].valid <= 1'b0;
            r_rptr              <= r_rptr + 1'b1;
         end
         if (w_push) begin
            r_ent[r_wptr] <= '{valid: 1'b1, rd: i_push_rd, data: i_push_data};
            r_wptr        <= r_wptr + 1'b1;
         end
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   always_comb begin
      o_rs1_busy_c = 1'b0;
      o_rs2_busy_c = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (r_ent[PTR_W'(i)].valid) begin
            if (r_ent[PTR_W'(i)].rd == i_rs1) o_rs1_busy_c = 1'b1;
            if (r_ent[PTR_W'(i)].rd == i_rs2) o_rs2_busy_c = 1'b1;
         end
      end
      if (i_rs1 == REG_ZERO) o_rs1_busy_c = 1'b0;
      if (i_rs2 == REG_ZERO) o_rs2_busy_c = 1'b0;
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: ALU has priority, LSU results queue up,
// and a starvation counter periodically holds the ALU off to drain the queue.
module rf_wb_arbiter
   import rv32_pkg::*;
#(
   parameter int unsigned DEPTH      = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input logic          clk,
   input logic          rst_n,
   rf_wb_arbiter_if.slave bus
);

   localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

   logic                  r_alu_stall;
   logic                  w_alu_stall_nxt;
   logic [STARVE_W-1:0]   r_starve;
   logic [STARVE_W-1:0]   w_starve_nxt;
   wb_req_t               w_head;
   logic                  w_empty;
   logic                  w_full;
   logic                  w_grant;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_squash;
   logic                  w_rs1_busy;
   logic                  w_rs2_busy;
   logic                  w_wen;
   logic [REG_ADDR_W-1:0] w_rd;
   logic [XLEN-1:0]       w_dat;

   assign w_grant  = bus.alu_valid & ~r_alu_stall;
   assign w_push   = bus.lsu_valid & ~w_full & (bus.lsu_rd != REG_ZERO);
   // A squashed head drains even while the ALU owns the port.
   assign w_pop    = ~w_empty & (~w_head.valid | ~w_grant);
   assign w_squash = w_grant & (bus.alu_rd != REG_ZERO);

   rf_wb_queue #(.DEPTH(DEPTH)) u_queue (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_push      (w_push),
      .i_push_rd   (bus.lsu_rd),
      .i_push_data (bus.lsu_data),
      .i_pop       (w_pop),
      .i_squash    (w_squash),
      .i_squash_rd (bus.alu_rd),
      .i_rs1       (bus.rs1),
      .i_rs2       (bus.rs2),
      .o_head_c    (w_head),
      .o_empty_c   (w_empty),
      .o_full_c    (w_full),
      .o_rs1_busy_c(w_rs1_busy),
      .o_rs2_busy_c(w_rs2_busy)
   );

   // Write-port grant mux.
   always_comb begin
      w_wen = 1'b0;
      w_rd  = REG_ZERO;
      w_dat = '0;
      if (w_grant) begin
         w_wen = (bus.alu_rd != REG_ZERO);
         w_rd  = bus.alu_rd;
         w_dat = bus.alu_data;
      end else if (w_head.valid) begin
         w_wen = 1'b1;
         w_rd  = w_head.rd;
         w_dat = w_head.data;
      end
   end

   // Starvation tracking: only a valid head blocked by an ALU grant counts.
   always_comb begin
      w_starve_nxt    = r_starve;
      w_alu_stall_nxt = 1'b0;
      if (w_empty || w_pop) begin
         w_starve_nxt = '0;
      end else if (w_head.valid && w_grant) begin
         if (r_starve == STARVE_W'(STARVE_MAX - 1)) begin
            w_starve_nxt    = '0;
            w_alu_stall_nxt = 1'b1;
         end else begin
            w_starve_nxt = r_starve + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_starve    <= '0;
         r_alu_stall <= 1'b0;
      end else begin
         r_starve    <= w_starve_nxt;
         r_alu_stall <= w_alu_stall_nxt;
      end
   end

   assign bus.wen       = w_wen;
   assign bus.rd        = w_rd;
   assign bus.Rd_dat    = w_dat;
   assign bus.alu_stall = r_alu_stall;
   assign bus.lsu_ready = ~w_full;
   assign bus.rs1_busy  = w_rs1_busy;
   assign bus.rs2_busy  = w_rs2_busy;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_rf_wb_arbiter;
   import rv32_pkg::*;

   localparam int unsigned DEPTH      = 2;
   localparam int unsigned STARVE_MAX = 4;

   logic clk = 1'b0;
   logic rst_n;

   rf_wb_arbiter_if bus ();

   rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          v;
      logic [4:0]  rd;
      logic [31:0] d;
   } ment_t;

   ment_t       mq[$];
   int          m_blk;
   bit          m_stall;
   logic [31:0] m_rf [32];
   logic [31:0] d_rf [32];
   int          d_wr_cnt;
   int          total;
   int          bad;

   logic        e_wen, e_ready, e_b1, e_b2, e_stall;
   logic [4:0]  e_rd;
   logic [31:0] e_dat;

   task automatic set_idle();
      bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
      bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
      bus.rs1 = '0; bus.rs2 = '0;
   endtask

   function automatic void model_reset();
      mq.delete();
      m_blk   = 0;
      m_stall = 1'b0;
   endfunction

   // Expected outputs for the current cycle from the model state and driven inputs.
   function automatic void model_eval();
      bit grant;
      grant   = bus.alu_valid && !m_stall;
      e_stall = m_stall;
      e_ready = (mq.size() < DEPTH);
      e_wen = 1'b0; e_rd = '0; e_dat = '0;
      if (grant) begin
         e_wen = (bus.alu_rd != 0); e_rd = bus.alu_rd; e_dat = bus.alu_data;
      end else if (mq.size() > 0 && mq[0].v) begin
         e_wen = 1'b1; e_rd = mq[0].rd; e_dat = mq[0].d;
      end
      e_b1 = 1'b0; e_b2 = 1'b0;
      foreach (mq[i]) begin
         if (mq[i].v && mq[i].rd == bus.rs1 && bus.rs1 != 0) e_b1 = 1'b1;
         if (mq[i].v && mq[i].rd == bus.rs2 && bus.rs2 != 0) e_b2 = 1'b1;
      end
   endfunction

   // Advance the model across one clock edge.
   function automatic void model_update();
      bit grant, pre_empty, ready, popped;
      grant     = bus.alu_valid && !m_stall;
      pre_empty = (mq.size() == 0);
      ready     = (mq.size() < DEPTH);
      popped    = !pre_empty && (!mq[0].v || !grant);
      if (popped) begin
         if (mq[0].v) m_rf[mq[0].rd] = mq[0].d;
         void'(mq.pop_front());
      end
      if (grant && bus.alu_rd != 0) begin
         m_rf[bus.alu_rd] = bus.alu_data;
         foreach (mq[i]) if (mq[i].rd == bus.alu_rd) mq[i].v = 1'b0;
      end
      if (bus.lsu_valid && ready && bus.lsu_rd != 0)
         mq.push_back('{v: 1'b1, rd: bus.lsu_rd, d: bus.lsu_data});
      m_stall = 1'b0;
      if (pre_empty || popped) begin
         m_blk = 0;
      end else begin
         m_blk++;
         if (m_blk == STARVE_MAX) begin
            m_stall = 1'b1;
            m_blk   = 0;
         end
      end
   endfunction

   // Called after the falling edge: record the DUT write, step the model, move past the next rising edge.
   task automatic tick();
      if (rst_n) begin
         if (bus.wen) begin
            d_rf[bus.rd] = bus.Rd_dat;
            d_wr_cnt++;
         end
         model_update();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      set_idle();
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd5; bus.lsu_data = 32'hDEADBEEF; bus.rs1 = 5'd5;
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (bus.wen !== 1'b0) begin bad++; $display("FAIL reset_wen got=%0b exp=0", bus.wen); end
      total++; if (bus.lsu_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", bus.lsu_ready); end
      total++; if (bus.rs1_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", bus.rs1_busy); end
      total++; if (bus.alu_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b exp=0", bus.alu_stall); end
      total++; if (bus.rd !== 5'd0 || bus.Rd_dat !== 32'd0) begin bad++; $display("FAIL reset_rd got=%0d/%h exp=0/0", bus.rd, bus.Rd_dat); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (bus.wen !== 1'b0) begin bad++; $display("FAIL push_wen0 got=%0b exp=0", bus.wen); end
      tick();
      bus.lsu_valid = 1'b0;
      @(negedge clk);
      total++; if (bus.wen !== 1'b1 || bus.rd !== 5'd5 || bus.Rd_dat !== 32'hDEADBEEF) begin
         bad++; $display("FAIL push_write got=%0b/%0d/%h exp=1/5/deadbeef", bus.wen, bus.rd, bus.Rd_dat); end
      total++; if (bus.rs1_busy !== 1'b1) begin bad++; $display("FAIL push_busy got=%0b exp=1", bus.rs1_busy); end
      tick();
      @(negedge clk);
      total++; if (bus.wen !== 1'b0 || bus.rs1_busy !== 1'b0) begin
         bad++; $display("FAIL push_drained got=%0b/%0b exp=0/0", bus.wen, bus.rs1_busy); end
      tick();
   endtask

   task automatic test_starvation();
      logic       exp_stall;
      logic [4:0] exp_rd;
      set_idle();
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h33;
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'h77;
      for (int c = 0; c < 12; c++) begin
         if (c == 1) begin bus.lsu_rd = 5'd8; bus.lsu_data = 32'h88; end
         if (c == 2) bus.lsu_valid = 1'b0;
         @(negedge clk);
         exp_stall = (c == 5 || c == 10);
         exp_rd    = (c == 5) ? 5'd7 : (c == 10) ? 5'd8 : 5'd3;
         total++; if (bus.alu_stall !== exp_stall) begin bad++; $display("FAIL starve_stall c=%0d got=%0b exp=%0b", c, bus.alu_stall, exp_stall); end
         total++; if (bus.wen !== 1'b1 || bus.rd !== exp_rd) begin bad++; $display("FAIL starve_rd c=%0d got=%0b/%0d exp=1/%0d", c, bus.wen, bus.rd, exp_rd); end
         if (c == 2) begin
            total++; if (bus.lsu_ready !== 1'b0) begin bad++; $display("FAIL starve_full got=%0b exp=0", bus.lsu_ready); end
         end
         tick();
      end
      set_idle();
   endtask

   task automatic test_squash();
      set_idle();
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h1;
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd9; bus.lsu_data = 32'h11;
      @(negedge clk); tick();
      bus.lsu_valid = 1'b0; bus.alu_rd = 5'd9; bus.alu_data = 32'h22; bus.rs1 = 5'd9;
      @(negedge clk);
      total++; if (bus.rs1_busy !== 1'b1) begin bad++; $display("FAIL squash_busy0 got=%0b exp=1", bus.rs1_busy); end
      tick();
      bus.alu_valid = 1'b0;
      @(negedge clk);
      total++; if (bus.rs1_busy !== 1'b0) begin bad++; $display("FAIL squash_busy1 got=%0b exp=0", bus.rs1_busy); end
      total++; if (bus.wen !== 1'b0) begin bad++; $display("FAIL squash_wen got=%0b exp=0", bus.wen); end
      tick();
      @(negedge clk);
      total++; if (bus.lsu_ready !== 1'b1 || bus.wen !== 1'b0) begin bad++; $display("FAIL squash_drain got=%0b/%0b exp=1/0", bus.lsu_ready, bus.wen); end
      tick();
      total++; if (d_rf[9] !== 32'h22) begin bad++; $display("FAIL squash_x9 got=%h exp=00000022", d_rf[9]); end
   endtask

   task automatic test_same_cycle();
      set_idle();
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'h40;
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd4; bus.lsu_data = 32'h44; bus.rs1 = 5'd4;
      @(negedge clk); tick();
      bus.alu_valid = 1'b0; bus.lsu_valid = 1'b0;
      @(negedge clk);
      total++; if (bus.rs1_busy !== 1'b1) begin bad++; $display("FAIL same_busy got=%0b exp=1", bus.rs1_busy); end
      total++; if (bus.wen !== 1'b1 || bus.rd !== 5'd4 || bus.Rd_dat !== 32'h44) begin
         bad++; $display("FAIL same_write got=%0b/%0d/%h exp=1/4/00000044", bus.wen, bus.rd, bus.Rd_dat); end
      tick();
      total++; if (d_rf[4] !== 32'h44) begin bad++; $display("FAIL same_x4 got=%h exp=00000044", d_rf[4]); end
   endtask

   task automatic test_rd_zero();
      int cnt0;
      cnt0 = d_wr_cnt;
      set_idle();
      bus.alu_valid = 1'b1; bus.alu_data = 32'h55; bus.lsu_valid = 1'b1; bus.lsu_data = 32'h66;
      for (int c = 0; c < 3; c++) begin
         if (c == 2) begin bus.alu_valid = 1'b0; bus.lsu_valid = 1'b0; end
         @(negedge clk);
         total++; if (bus.wen !== 1'b0) begin bad++; $display("FAIL zero_wen c=%0d got=%0b exp=0", c, bus.wen); end
         total++; if (bus.lsu_ready !== 1'b1) begin bad++; $display("FAIL zero_ready c=%0d got=%0b exp=1", c, bus.lsu_ready); end
         total++; if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0) begin
            bad++; $display("FAIL zero_busy c=%0d got=%0b/%0b exp=0/0", c, bus.rs1_busy, bus.rs2_busy); end
         tick();
      end
      total++; if (d_wr_cnt !== cnt0) begin bad++; $display("FAIL zero_writes got=%0d exp=%0d", d_wr_cnt, cnt0); end
   endtask

   task automatic test_mid_reset();
      int cnt0;
      set_idle();
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd2; bus.alu_data = 32'h2;
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd10; bus.lsu_data = 32'hA0;
      @(negedge clk); tick();
      bus.lsu_rd = 5'd11; bus.lsu_data = 32'hB0; bus.rs1 = 5'd10; bus.rs2 = 5'd11;
      @(negedge clk); tick();
      bus.lsu_valid = 1'b0;
      @(negedge clk);
      total++; if (bus.lsu_ready !== 1'b0 || bus.rs1_busy !== 1'b1) begin
         bad++; $display("FAIL mid_full got=%0b/%0b exp=0/1", bus.lsu_ready, bus.rs1_busy); end
      #2;
      rst_n = 1'b0;
      bus.alu_valid = 1'b0;
      model_reset();
      #1;
      total++; if (bus.wen !== 1'b0 || bus.lsu_ready !== 1'b1) begin
         bad++; $display("FAIL mid_rst_out got=%0b/%0b exp=0/1", bus.wen, bus.lsu_ready); end
      total++; if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0 || bus.alu_stall !== 1'b0) begin
         bad++; $display("FAIL mid_rst_busy got=%0b/%0b/%0b exp=0/0/0", bus.rs1_busy, bus.rs2_busy, bus.alu_stall); end
      cnt0 = d_wr_cnt;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         total++; if (bus.wen !== 1'b0 || bus.lsu_ready !== 1'b1) begin
            bad++; $display("FAIL mid_after c=%0d got=%0b/%0b exp=0/1", c, bus.wen, bus.lsu_ready); end
         tick();
      end
      total++; if (d_wr_cnt !== cnt0) begin bad++; $display("FAIL mid_writes got=%0d exp=%0d", d_wr_cnt, cnt0); end
   endtask

   task automatic test_random();
      set_idle();
      for (int n = 0; n < 400; n++) begin
         if (!m_stall) begin
            bus.alu_valid = ($urandom_range(0, 99) < 55);
            bus.alu_rd    = 5'($urandom_range(0, 7));
            bus.alu_data  = $urandom;
         end
         bus.lsu_valid = ($urandom_range(0, 99) < 50);
         bus.lsu_rd    = 5'($urandom_range(0, 7));
         bus.lsu_data  = $urandom;
         bus.rs1       = 5'($urandom_range(0, 7));
         bus.rs2       = 5'($urandom_range(0, 7));
         @(negedge clk);
         model_eval();
         total++; if (bus.wen !== e_wen) begin bad++; $display("FAIL rnd_wen n=%0d got=%0b exp=%0b", n, bus.wen, e_wen); end
         total++; if (bus.rd !== e_rd) begin bad++; $display("FAIL rnd_rd n=%0d got=%0d exp=%0d", n, bus.rd, e_rd); end
         total++; if (bus.Rd_dat !== e_dat) begin bad++; $display("FAIL rnd_dat n=%0d got=%h exp=%h", n, bus.Rd_dat, e_dat); end
         total++; if (bus.alu_stall !== e_stall) begin bad++; $display("FAIL rnd_stall n=%0d got=%0b exp=%0b", n, bus.alu_stall, e_stall); end
         total++; if (bus.lsu_ready !== e_ready) begin bad++; $display("FAIL rnd_ready n=%0d got=%0b exp=%0b", n, bus.lsu_ready, e_ready); end
         total++; if (bus.rs1_busy !== e_b1) begin bad++; $display("FAIL rnd_busy1 n=%0d got=%0b exp=%0b", n, bus.rs1_busy, e_b1); end
         total++; if (bus.rs2_busy !== e_b2) begin bad++; $display("FAIL rnd_busy2 n=%0d got=%0b exp=%0b", n, bus.rs2_busy, e_b2); end
         tick();
      end
      set_idle();
      repeat (DEPTH + 2) begin
         @(negedge clk);
         tick();
      end
      for (int r = 0; r < 32; r++) begin
         total++; if (d_rf[r] !== m_rf[r]) begin bad++; $display("FAIL rnd_rf x%0d got=%h exp=%h", r, d_rf[r], m_rf[r]); end
      end
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      d_wr_cnt = 0;
      for (int r = 0; r < 32; r++) begin
         m_rf[r] = '0;
         d_rf[r] = '0;
      end
      rst_n = 1'b0;
      set_idle();
      model_reset();
      test_reset();
      test_starvation();
      test_squash();
      test_same_cycle();
      test_rd_zero();
      test_mid_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Shares the single register-file write port (wen/rd/Rd_dat) between two writeback sources: the in-order ALU pipeline and the variable-latency load/store unit (LSU). ALU writebacks have priority. LSU results are buffered in a small queue, and a starvation counter forces an LSU slot when needed. The block also reports, combinationally, whether a source register has a load result still queued, so the decode stage can stall.

Parameters:
- DEPTH, 2, LSU queue entries (power of two, minimum 2)
- STARVE_MAX, 4, cycles the queue head may wait before the ALU is held off

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU writeback request this cycle
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- alu_stall  out  1  registered; ALU writeback not accepted this cycle, core holds request
- lsu_valid  in  1  LSU result valid
- lsu_ready  out  1  queue can accept an LSU result
- lsu_rd  in  5  LSU destination register
- lsu_data  in  32  load data
- wen  out  1  register-file write enable
- rd  out  5  register-file write address
- Rd_dat  out  32  register-file write data
- rs1  in  5  decode source 1
- rs2  in  5  decode source 2
- rs1_busy  out  1  rs1 has a queued load result
- rs2_busy  out  1  rs2 has a queued load result

Behaviour:
- Reset is asynchronous, active-low, on clk/rst_n. During reset: queue empty, all entries invalid, starve counter 0, alu_stall 0. Consequently wen=0, rd=0, Rd_dat=0, lsu_ready=1, busy outputs 0.
- LSU push: accepted when lsu_valid & lsu_ready. lsu_ready = !full, using registered occupancy, so a simultaneous pop does not enable a push when full.
- An accepted LSU result with lsu_rd=0 is dropped and never enqueued.
- Write-port selection is combinational, with zero added latency:
  - If alu_valid & !alu_stall: wen=(alu_rd!=0), rd=alu_rd, Rd_dat=alu_data.
  - Else if queue head is valid: wen=1, rd/Rd_dat from the head; the head pops at the clock edge.
  - Else wen=0, rd=0, Rd_dat=0.
- Invalidated (squashed) entries at the head pop silently, with wen=0, in the cycle they reach the head.
- WAW ordering: when an ALU write with alu_rd!=0 is granted, every valid queued entry with matching rd is invalidated at the same edge. The entry is squashed but not removed; occupancy is unchanged until it pops.
- An LSU result pushed in the same cycle as a granted ALU write to the same rd is enqueued valid, because it is younger.
- Starvation:
  - The counter increments each cycle the valid head is blocked by an ALU grant.
  - It clears on a pop or when the queue is empty.
  - When the counter reaches STARVE_MAX, alu_stall=1 for exactly the next cycle and the counter clears.
  - In that cycle the head writes, and the core must keep alu_valid/alu_rd/alu_data stable.
- rsN_busy = (rsN!=0) & any valid queued entry has rd==rsN. Squashed entries do not count. rs==0 is never busy.
- Reset mid-operation discards all queued results with no write; no partial state survives.
- Queue pointers wrap modulo DEPTH. full/empty come from an occupancy count of width clog2(DEPTH)+1.

Decomposition:
- Shared package rv32_pkg holds XLEN=32, REG_ADDR_W=5, REG_ZERO=5'd0, and a wb_req_t struct {valid, rd, data}.
- One sub-module, rf_wb_queue: a circular buffer with per-entry valid bits, push/pop ports, squash-by-rd input and a two-address busy lookup.
- The arbiter top holds the grant mux, starvation counter and alu_stall register.

Test Plan:
- Reset with lsu_valid=1 held -> wen=0, lsu_ready=1, busy=0; after release, one push of rd=5, data=0xDEADBEEF with alu_valid=0 -> next cycle wen=1, rd=5, Rd_dat=0xDEADBEEF, rs1=5 busy for 1 cycle only.
- alu_valid=1 with rd=3 every cycle; LSU pushes rd=7, rd=8 -> queue full, lsu_ready=0; after STARVE_MAX=4 blocked cycles, alu_stall=1 for one cycle and rd=7 is written; the pattern repeats for rd=8.
- Queue holds rd=9 (0x11); ALU writes rd=9 (0x22) -> rs1=9 busy drops the next cycle; when the entry reaches the head, wen=0; register-file model ends with x9=0x22.
- Same cycle: ALU writes rd=4, LSU pushes rd=4 (0x44) -> entry stays valid; x4 ends 0x44 after it drains.
- LSU push rd=0 and ALU write rd=0 -> wen never asserted, occupancy unchanged, rs1=0/rs2=0 busy=0.
- Two entries queued, rst_n pulsed low mid-cycle -> outputs return to reset values immediately, no writes afterwards, lsu_ready=1.
